// File: rtl/cpu_status_sender_pkg.sv
// Shared constants for the CPU status frame sender:
// FSM state encodings and the ASCII codes used in a frame.
package cpu_status_sender_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HI   = 3'd1;
    localparam logic [2:0] ST_LO   = 3'd2;
    localparam logic [2:0] ST_SP   = 3'd3;
    localparam logic [2:0] ST_CR   = 3'd4;
    localparam logic [2:0] ST_LF   = 3'd5;

    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_A  = 8'h41;

endpackage

// File: rtl/sm_hex2ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
// Maps 0-9 onto '0'-'9' and 10-15 onto 'A'-'F'.
module sm_hex2ascii
    import cpu_status_sender_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] asc
);

    always_comb begin
        if (nib < 4'd10) begin
            asc = ASC_0 + {4'h0, nib};
        end else begin
            asc = ASC_A + {4'h0, nib} - 8'd10;
        end
    end

endmodule

// File: rtl/cpu_status_sender.sv
// Streams a 64-bit CPU status snapshot as one line of ASCII hex
// over a valid/ready byte interface, with one pending re-trigger.
module cpu_status_sender
    import cpu_status_sender_pkg::*;
#(
    parameter int EOL_CRLF = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig,
    input  logic [63:0] cpust_snd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    logic [2:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [63:0] snap_q, snap_d;
    logic        pend_q, pend_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        done_q, done_d;

    logic        xfer;
    logic        last;
    logic [5:0]  bit_hi;
    logic [7:0]  byte_sel;
    logic [3:0]  nib;
    logic [7:0]  nib_asc;

    assign xfer = tx_valid_q & tx_ready;
    assign last = xfer & (state_q == ST_LF);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_HI;
                    idx_d   = 3'd0;
                    snap_d  = cpust_snd;
                end
            end
            ST_HI: begin
                if (xfer) state_d = ST_LO;
            end
            ST_LO: begin
                if (xfer) begin
                    if (idx_q != 3'd7) begin
                        state_d = ST_SP;
                    end else if (EOL_CRLF != 0) begin
                        state_d = ST_CR;
                    end else begin
                        state_d = ST_LF;
                    end
                end
            end
            ST_SP: begin
                if (xfer) begin
                    state_d = ST_HI;
                    idx_d   = idx_q + 3'd1;
                end
            end
            ST_CR: begin
                if (xfer) state_d = ST_LF;
            end
            ST_LF: begin
                if (xfer) begin
                    idx_d = 3'd0;
                    // A trig on this very edge counts as pending too.
                    if (pend_q | trig) begin
                        state_d = ST_HI;
                        snap_d  = cpust_snd;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase

        if (last) begin
            pend_d = 1'b0;
        end else if (trig && state_q != ST_IDLE) begin
            pend_d = 1'b1;
        end
    end

    // Encode the char of the upcoming state so tx_data can be a flop.
    assign bit_hi   = 6'd63 - {idx_d, 3'b000};
    assign byte_sel = snap_d[bit_hi -: 8];
    assign nib      = (state_d == ST_HI) ? byte_sel[7:4] : byte_sel[3:0];

    sm_hex2ascii u_hex (
        .nib (nib),
        .asc (nib_asc)
    );

    always_comb begin
        tx_valid_d = (state_d != ST_IDLE);
        done_d     = last;
        case (state_d)
            ST_HI,
            ST_LO:   tx_data_d = nib_asc;
            ST_SP:   tx_data_d = ASC_SP;
            ST_CR:   tx_data_d = ASC_CR;
            ST_LF:   tx_data_d = ASC_LF;
            default: tx_data_d = tx_data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            snap_q     <= 64'd0;
            pend_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            pend_q     <= pend_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE) | pend_q;

endmodule

// File: tb/tb_cpu_status_sender.sv
// Directed checks of the status sender, CRLF and LF-only builds.
module tb_cpu_status_sender;

    logic        clk;
    logic        rst_n;
    logic        trig;
    logic [63:0] cpust_snd;
    logic        tx_ready;
    logic [7:0]  d1_data, d2_data;
    logic        d1_valid, d2_valid;
    logic        d1_busy, d2_busy;
    logic        d1_done, d2_done;

    logic        sel;
    logic [7:0]  m_data;
    logic        m_valid, m_busy, m_done;

    int nvec;
    int nerr;
    logic [7:0] rx [0:31];

    cpu_status_sender #(.EOL_CRLF(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .cpust_snd (cpust_snd),
        .tx_data   (d1_data),
        .tx_valid  (d1_valid),
        .tx_ready  (tx_ready),
        .busy      (d1_busy),
        .done      (d1_done)
    );

    cpu_status_sender #(.EOL_CRLF(0)) dut_lf (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .cpust_snd (cpust_snd),
        .tx_data   (d2_data),
        .tx_valid  (d2_valid),
        .tx_ready  (tx_ready),
        .busy      (d2_busy),
        .done      (d2_done)
    );

    assign m_data  = sel ? d2_data  : d1_data;
    assign m_valid = sel ? d2_valid : d1_valid;
    assign m_busy  = sel ? d2_busy  : d1_busy;
    assign m_done  = sel ? d2_done  : d1_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // mode 0 plain, 1 stalls + input change, 2 extra trigs, 3 input change
    task automatic recv(input int n, input int mode, output int cyc);
        int k;
        int t;
        bit hold;
        logic [7:0] held;
        k = 0;
        t = 0;
        hold = 0;
        held = 8'h00;
        while (k < n && t < 400) begin
            t++;
            if (hold) begin
                chk("hold_data", m_data, held);
                chk("hold_valid", m_valid, 1'b1);
            end
            tx_ready = (mode == 1) ? ((t % 3) == 1) : 1'b1;
            trig = (mode == 2) && (t == 3 || t == 6 || t == 9);
            if (mode == 1 && t == 1) cpust_snd = 64'hFFFF_FFFF_FFFF_FFFF;
            if (mode == 2 && t == 20) cpust_snd = 64'hFEDC_BA98_7654_3210;
            if (mode == 3 && t == 2) cpust_snd = 64'hDEAD_BEEF_CAFE_F00D;
            hold = m_valid && !tx_ready;
            held = m_data;
            if (m_valid && tx_ready) begin
                rx[k] = m_data;
                k++;
            end
            @(negedge clk);
        end
        trig = 1'b0;
        tx_ready = 1'b1;
        cyc = t;
        if (k < n) chk("timeout", k, n);
    endtask

    task automatic cmp_frame(input string s, input bit crlf);
        for (int i = 0; i < 23; i++) begin
            chk($sformatf("chr%0d", i), rx[i], s[i]);
        end
        if (crlf) begin
            chk("cr", rx[23], 8'h0D);
            chk("lf", rx[24], 8'h0A);
        end else begin
            chk("lf", rx[23], 8'h0A);
        end
    endtask

    task automatic pulse_trig(input logic [63:0] v);
        cpust_snd = v;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        chk("latency", m_valid, 1'b1);
    endtask

    task automatic end_chk(input bit exp_busy);
        chk("done_hi", m_done, 1'b1);
        chk("end_busy", m_busy, exp_busy);
        if (!exp_busy) begin
            chk("end_valid", m_valid, 1'b0);
            @(negedge clk);
            chk("done_lo", m_done, 1'b0);
            chk("idle_busy", m_busy, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data", m_data, 8'h00);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_done", m_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        nvec = 0;
        nerr = 0;
        sel = 1'b0;
        trig = 1'b0;
        tx_ready = 1'b1;
        cpust_snd = 64'd0;
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();

        pulse_trig(64'h0123_4567_89AB_CDEF);
        recv(25, 0, cyc);
        chk("no_bubble", cyc, 25);
        cmp_frame("01 23 45 67 89 AB CD EF", 1'b1);
        end_chk(1'b0);

        pulse_trig(64'h0123_4567_89AB_CDEF);
        recv(25, 1, cyc);
        cmp_frame("01 23 45 67 89 AB CD EF", 1'b1);
        end_chk(1'b0);

        pulse_trig(64'h1122_3344_5566_7788);
        recv(25, 2, cyc);
        cmp_frame("11 22 33 44 55 66 77 88", 1'b1);
        chk("b2b_valid", m_valid, 1'b1);
        end_chk(1'b1);
        recv(25, 3, cyc);
        cmp_frame("FE DC BA 98 76 54 32 10", 1'b1);
        end_chk(1'b0);
        repeat (30) @(negedge clk);
        chk("no_third", m_valid, 1'b0);

        pulse_trig(64'h0123_4567_89AB_CDEF);
        recv(10, 0, cyc);
        do_reset();
        repeat (3) @(negedge clk);
        chk("abort_quiet", m_valid, 1'b0);
        pulse_trig(64'h0123_4567_89AB_CDEF);
        recv(25, 0, cyc);
        cmp_frame("01 23 45 67 89 AB CD EF", 1'b1);
        end_chk(1'b0);

        sel = 1'b1;
        do_reset();
        pulse_trig(64'h0000_0000_0000_00A5);
        recv(24, 0, cyc);
        chk("lf_len", cyc, 24);
        cmp_frame("00 00 00 00 00 00 00 A5", 1'b0);
        end_chk(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
